// File: rtl/bcd2ascii_pkg.sv
// Shared constants for the BCD-to-ASCII line transmitter: ASCII codes,
// FSM state encodings and field offsets of the 17-bit signed BCD word.
package bcd2ascii_pkg;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Word layout {sign, 3'b0, thousands[0], hundreds, tens, ones}
  localparam int BCD_W       = 17;
  localparam int BCD_SIGN    = 16;
  localparam int BCD_TH      = 12;
  localparam int BCD_HU_LSB  = 8;
  localparam int BCD_TEN_LSB = 4;
  localparam int BCD_ONE_LSB = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIGN = 3'd1,
    TH   = 3'd2,
    HU   = 3'd3,
    TEN  = 3'd4,
    ONE  = 3'd5,
    CR   = 3'd6,
    LF   = 3'd7
  } state_t;

  typedef struct packed {
    logic       sign;
    logic       th;
    logic [3:0] hu;
    logic [3:0] te;
    logic [3:0] on;
  } line_t;

  function automatic line_t to_line(input logic [BCD_W-1:0] w);
    line_t l;
    l.sign = w[BCD_SIGN];
    l.th   = w[BCD_TH];
    l.hu   = w[BCD_HU_LSB +: 4];
    l.te   = w[BCD_TEN_LSB +: 4];
    l.on   = w[BCD_ONE_LSB +: 4];
    return l;
  endfunction

  // Non-decimal nibbles are shown as '?' rather than silently wrapping.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
  endfunction

endpackage

// File: rtl/bcd_fifo.sv
// Small show-ahead FIFO for BCD words; the head word is readable
// combinationally so the consumer can pop and use it in the same cycle.
module bcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Push while full is only issued together with a pop, so the slot being
  // overwritten is the one whose contents leave on this same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bcd2ascii_tx.sv
// Formats signed 4-digit BCD words as ASCII text lines on a valid/ready
// character stream, with leading-zero suppression and an input FIFO.
module bcd2ascii_tx
  import bcd2ascii_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit CRLF  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [BCD_W-1:0]  bcd,
  input  logic              bcd_vld,
  output logic [7:0]        ch_data,
  output logic              ch_vld,
  input  logic              ch_rdy,
  output logic              busy,
  output logic              ovf,
  output logic [7:0]        ovf_cnt
);

  logic [BCD_W-1:0]        fifo_rdata;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    transfer;
  logic                    unused_pad;

  state_t state;
  state_t adv;
  line_t  cur_line;
  line_t  head;

  bcd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BCD_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (bcd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic state_t first_digit(input line_t l);
    if (l.th)              return TH;
    else if (l.hu != 4'h0) return HU;
    else if (l.te != 4'h0) return TEN;
    else                   return ONE;
  endfunction

  // A minus sign on zero magnitude would print "-0", so it is suppressed.
  function automatic state_t first_state(input line_t l);
    if (l.sign && (l.th || l.hu != 4'h0 || l.te != 4'h0 || l.on != 4'h0))
      return SIGN;
    return first_digit(l);
  endfunction

  // Once any digit is emitted all lower digits follow, so only SIGN skips.
  function automatic state_t after(input state_t s, input line_t l);
    case (s)
      SIGN:    return first_digit(l);
      TH:      return HU;
      HU:      return TEN;
      TEN:     return ONE;
      ONE:     return CRLF ? CR : LF;
      CR:      return LF;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [7:0] char_of(input state_t s, input line_t l);
    case (s)
      SIGN:    return ASCII_MINUS;
      TH:      return digit_char({3'b000, l.th});
      HU:      return digit_char(l.hu);
      TEN:     return digit_char(l.te);
      ONE:     return digit_char(l.on);
      CR:      return ASCII_CR;
      LF:      return ASCII_LF;
      default: return 8'h00;
    endcase
  endfunction

  assign head       = to_line(fifo_rdata);
  assign unused_pad = ^fifo_rdata[15:13];
  assign adv        = after(state, cur_line);
  assign transfer   = ch_vld && ch_rdy;
  // Popping on the LF transfer keeps back-to-back lines bubble-free.
  assign pop        = !fifo_empty && ((state == IDLE) || (state == LF && transfer));
  assign push       = bcd_vld && (!fifo_full || pop);
  assign busy       = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cur_line <= '0;
      ch_data  <= 8'h00;
      ch_vld   <= 1'b0;
      ovf      <= 1'b0;
      ovf_cnt  <= 8'h00;
    end else begin
      ovf <= bcd_vld && !push;
      if (bcd_vld && !push && ovf_cnt != 8'hFF)
        ovf_cnt <= ovf_cnt + 8'h01;

      if (pop) begin
        state    <= first_state(head);
        cur_line <= head;
        ch_data  <= char_of(first_state(head), head);
        ch_vld   <= 1'b1;
      end else if (transfer) begin
        if (state == LF) begin
          state   <= IDLE;
          ch_data <= 8'h00;
          ch_vld  <= 1'b0;
        end else begin
          state   <= adv;
          ch_data <= char_of(adv, cur_line);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd2ascii_tx.sv
// Directed bench for bcd2ascii_tx: a line-formatting model feeds a character
// scoreboard checked every cycle, plus literal line expectations.
module tb_bcd2ascii_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [16:0] bcd = '0;
  logic        bcd_vld = 1'b0;
  logic        bcd_vld_lf = 1'b0;
  logic        ch_rdy = 1'b1;
  logic        ch_rdy_lf = 1'b1;

  logic [7:0]  ch_data, ch_data_lf;
  logic        ch_vld, ch_vld_lf;
  logic        busy, busy_lf;
  logic        ovf, ovf_lf;
  logic [7:0]  ovf_cnt, ovf_cnt_lf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int send_cyc = 0;
  int idle_cyc = 0;
  int ovf_seen = 0;

  logic [7:0] exp_q [2][$];
  logic [7:0] got_q [2][$];
  int         got_cyc [2][$];
  logic       prev_stall [2];
  logic [7:0] prev_data [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd2ascii_tx #(.DEPTH(4), .CRLF(1'b1)) dut (
    .clk(clk), .rstn(rstn), .bcd(bcd), .bcd_vld(bcd_vld),
    .ch_data(ch_data), .ch_vld(ch_vld), .ch_rdy(ch_rdy),
    .busy(busy), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  bcd2ascii_tx #(.DEPTH(4), .CRLF(1'b0)) dut_lf (
    .clk(clk), .rstn(rstn), .bcd(bcd), .bcd_vld(bcd_vld_lf),
    .ch_data(ch_data_lf), .ch_vld(ch_vld_lf), .ch_rdy(ch_rdy_lf),
    .busy(busy_lf), .ovf(ovf_lf), .ovf_cnt(ovf_cnt_lf)
  );

  // Expected text of one line, straight from the formatting rules.
  task automatic push_line(input int inst, input logic [16:0] w, input bit crlf);
    int d [4];
    bit started;
    d[0] = int'(w[12]);
    d[1] = int'(w[11:8]);
    d[2] = int'(w[7:4]);
    d[3] = int'(w[3:0]);
    if (w[16] && (d[0] + d[1] + d[2] + d[3]) != 0) exp_q[inst].push_back(8'h2D);
    started = 0;
    for (int i = 0; i < 4; i++) begin
      if (started || d[i] != 0 || i == 3) begin
        started = 1;
        exp_q[inst].push_back(d[i] > 9 ? 8'h3F : 8'(8'h30 + d[i]));
      end
    end
    if (crlf) exp_q[inst].push_back(8'h0D);
    exp_q[inst].push_back(8'h0A);
  endtask

  task automatic monitor_one(input int i, input logic vld, input logic rdy, input logic [7:0] data);
    logic [7:0] e;
    if (prev_stall[i]) begin
      checks++;
      if (!vld || data !== prev_data[i]) begin
        errors++;
        $display("FAIL hold[%0d] cyc %0d: vld=%b data=%h, required vld=1 data=%h", i, cyc, vld, data, prev_data[i]);
      end
    end
    if (vld && rdy) begin
      checks++;
      if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL char[%0d] cyc %0d: got %h, required no character", i, cyc, data);
      end else begin
        e = exp_q[i].pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL char[%0d] cyc %0d: got %h, required %h", i, cyc, data, e);
        end
      end
      got_q[i].push_back(data);
      got_cyc[i].push_back(cyc);
    end
    prev_stall[i] = vld && !rdy;
    prev_data[i]  = data;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      if (ovf) ovf_seen++;
      monitor_one(0, ch_vld, ch_rdy, ch_data);
      monitor_one(1, ch_vld_lf, ch_rdy_lf, ch_data_lf);
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, req, req);
    end
  endtask

  task automatic send(input logic [16:0] w, input bit to_lf, input bit dropped);
    bcd = w;
    if (to_lf) bcd_vld_lf = 1'b1; else bcd_vld = 1'b1;
    send_cyc = cyc;
    if (!dropped) push_line(to_lf ? 1 : 0, w, !to_lf);
    @(posedge clk); #2;
    bcd_vld = 1'b0;
    bcd_vld_lf = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!busy && !busy_lf && exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
        done = 1;
        idle_cyc = cyc;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: busy=%b pending=%0d, required idle", name, busy, exp_q[0].size());
    end
    @(posedge clk); #2;
  endtask

  task automatic check_got(input string name, input int inst, input logic [7:0] e [$]);
    checks++;
    if (got_q[inst].size() != e.size()) begin
      errors++;
      $display("FAIL %s length: got %0d chars, required %0d", name, got_q[inst].size(), e.size());
    end
    for (int i = 0; i < e.size() && i < got_q[inst].size(); i++) begin
      checks++;
      if (got_q[inst][i] !== e[i]) begin
        errors++;
        $display("FAIL %s char %0d: got %h, required %h", name, i, got_q[inst][i], e[i]);
      end
    end
    got_q[inst].delete();
    got_cyc[inst].delete();
  endtask

  initial begin
    logic [7:0] e [$];
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("reset ch_vld", int'(ch_vld), 0);
    check("reset ch_data", int'(ch_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset ovf", int'(ovf), 0);
    check("reset ovf_cnt", int'(ovf_cnt), 0);
    rstn = 1'b1;
    @(posedge clk); #2;

    // Negative number, full width, latency and back-to-back output
    send(17'h11023, 0, 0);
    wait_idle("line 11023");
    check("first char latency", (got_cyc[0].size() > 0) ? got_cyc[0][0] : -1, send_cyc + 2);
    if (got_cyc[0].size() == 7)
      check("consecutive chars", got_cyc[0][6] - got_cyc[0][0], 6);
    check("busy drop after LF", idle_cyc, (got_cyc[0].size() > 0) ? got_cyc[0][got_cyc[0].size()-1] + 1 : -1);
    e = '{8'h2D, 8'h31, 8'h30, 8'h32, 8'h33, 8'h0D, 8'h0A};
    check_got("line 11023", 0, e);
    $display("txn 11023 done at cycle %0d", idle_cyc);

    // Zero and negative zero
    send(17'h00000, 0, 0);
    wait_idle("line 00000");
    e = '{8'h30, 8'h0D, 8'h0A};
    check_got("line 00000", 0, e);
    send(17'h10000, 0, 0);
    wait_idle("line 10000");
    check_got("line 10000", 0, e);
    $display("txn 00000/10000 done at cycle %0d", idle_cyc);

    // Stalls with ready toggling
    ch_rdy = 1'b0;
    send(17'h00045, 0, 0);
    for (int i = 0; i < 12; i++) begin
      ch_rdy = ~ch_rdy;
      @(posedge clk); #2;
    end
    ch_rdy = 1'b1;
    wait_idle("line 00045");
    e = '{8'h34, 8'h35, 8'h0D, 8'h0A};
    check_got("line 00045", 0, e);
    $display("txn 00045 stalled done at cycle %0d", idle_cyc);

    // Non-decimal digit, and LF-only terminator
    send(17'h000A7, 0, 0);
    wait_idle("line 000A7");
    e = '{8'h3F, 8'h37, 8'h0D, 8'h0A};
    check_got("line 000A7", 0, e);
    send(17'h00007, 1, 0);
    wait_idle("line 00007 lf");
    e = '{8'h37, 8'h0A};
    check_got("line 00007 lf", 1, e);
    $display("txn 000A7/00007 done at cycle %0d", idle_cyc);

    // Overflow: five accepted while stalled, sixth dropped
    ch_rdy = 1'b0;
    ovf_seen = 0;
    send(17'h0E123, 0, 0);
    send(17'h01000, 0, 0);
    send(17'h10009, 0, 0);
    send(17'h00050, 0, 0);
    send(17'h000F0, 0, 0);
    send(17'h00999, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    check("ovf pulses", ovf_seen, 1);
    check("ovf_cnt", int'(ovf_cnt), 1);
    check("busy while stalled", int'(busy), 1);
    ch_rdy = 1'b1;
    wait_idle("overflow lines");
    e = '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A,
          8'h31, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A,
          8'h2D, 8'h39, 8'h0D, 8'h0A,
          8'h35, 8'h30, 8'h0D, 8'h0A,
          8'h3F, 8'h30, 8'h0D, 8'h0A};
    check_got("overflow lines", 0, e);
    $display("txn overflow done at cycle %0d ovf_cnt=%0d", idle_cyc, ovf_cnt);

    // Asynchronous reset while stalled in TEN
    ch_rdy = 1'b0;
    send(17'h00045, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("stalled vld", int'(ch_vld), 1);
    check("stalled in TEN", int'(ch_data), 'h34);
    #1 rstn = 1'b0;
    #1;
    check("async rst ch_vld", int'(ch_vld), 0);
    check("async rst ovf_cnt", int'(ovf_cnt), 0);
    check("async rst busy", int'(busy), 0);
    exp_q[0].delete();
    got_q[0].delete();
    got_cyc[0].delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    ch_rdy = 1'b1;
    @(posedge clk); #2;
    send(17'h00007, 0, 0);
    wait_idle("line after reset");
    e = '{8'h37, 8'h0D, 8'h0A};
    check_got("line after reset", 0, e);
    $display("txn reset-recovery done at cycle %0d", idle_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
